puf_scan_response_capture: RTL

- Receive-side partner of the PUF scan-enable counter.
- Monitors the scan-enable line during an authentication run and serially captures the scan-chain output bits shifted while scan-enable is low.
- Checks the observed shift-window length against the programmed l_scan.
- Presents the captured PUF response, its length and error flags to the authentication controller.

---
 rtl/puf_scan_pkg.sv | 34 +++
 rtl/puf_misr16.sv | 32 +++
 rtl/puf_scan_response_capture.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/puf_scan_pkg.sv
// -----------------------------------------------------------------------------
// puf_scan_pkg
// Shared types and constants for the PUF scan response capture block.
//   state_t         : capture FSM states (IDLE, ARMED, SHIFT, DONE)
//   CNT_W_DEFAULT   : default width of the shift-length counter / l_scan
//   RESP_W_DEFAULT  : default width of the captured response register
//   MISR_POLY/SEED  : 16-bit MISR constants, x^16 + x^12 + x^5 + 1
//   misr_next()     : one MISR absorption step
// -----------------------------------------------------------------------------
package puf_scan_pkg;

  localparam int CNT_W_DEFAULT  = 16;
  localparam int RESP_W_DEFAULT = 64;

  // Low 16 coefficients of x^16 + x^12 + x^5 + 1 (the x^16 term is implicit).
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Galois-form step: the incoming bit is folded into the MSB feedback.
  function automatic logic [15:0] misr_next(input logic [15:0] sig,
                                            input logic        din);
    logic fb;
    fb = sig[15] ^ din;
    return {sig[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
  endfunction

endpackage : puf_scan_pkg

// File: rtl/puf_misr16.sv
// -----------------------------------------------------------------------------
// puf_misr16
// 16-bit signature register that compacts the serial scan stream.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset, clears the signature to 0
//   seed_load : load MISR_SEED (takes priority over shift_en)
//   shift_en  : absorb din this cycle
//   din       : serial input bit
//   sig       : current signature
// -----------------------------------------------------------------------------
module puf_misr16
  import puf_scan_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_load,
  input  logic        shift_en,
  input  logic        din,
  output logic [15:0] sig
);

  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= '0;
    end else if (seed_load) begin
      sig <= MISR_SEED;
    end else if (shift_en) begin
      sig <= misr_next(sig, din);
    end
  end

endmodule : puf_misr16

// File: rtl/puf_scan_response_capture.sv
// -----------------------------------------------------------------------------
// puf_scan_response_capture
// Receive-side partner of the PUF scan-enable counter. During an
// authentication run it watches se_in, serially captures scan_in on every
// cycle se_in is low, and on the first high se_in after the window publishes
// the captured response, its length and error flags.
//
// Optional build macro: PUF_MISR_EN adds a 16-bit MISR over the scan stream
// and the misr_sig output.
//
// Ports:
//   clk           : system clock, rising edge
//   rst           : synchronous active-high reset
//   capture_start : run enable, held high for the whole run; low aborts
//   se_in         : scan enable from the counter, 0 = shift window
//   scan_in       : serial scan-chain bit, valid while se_in = 0
//   l_scan        : expected window length, sampled at the SHIFT->DONE edge
//   resp_data     : captured bits, most recent bit in the LSB
//   resp_len      : number of se_in-low cycles observed (saturating)
//   resp_valid    : high while in DONE
//   busy          : high in ARMED or SHIFT
//   err_len       : resp_len != l_scan (valid with resp_valid)
//   err_ovf       : more than RESP_W bits were shifted (valid with resp_valid)
//   misr_sig      : (PUF_MISR_EN only) signature loaded at SHIFT->DONE
// -----------------------------------------------------------------------------
module puf_scan_response_capture
  import puf_scan_pkg::*;
#(
  parameter int RESP_W = RESP_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture_start,
  input  logic              se_in,
  input  logic              scan_in,
  input  logic [CNT_W-1:0]  l_scan,
  output logic [RESP_W-1:0] resp_data,
  output logic [CNT_W-1:0]  resp_len,
  output logic              resp_valid,
  output logic              busy,
  output logic              err_len,
  output logic              err_ovf
`ifdef PUF_MISR_EN
  ,
  output logic [15:0]       misr_sig
`endif
);

  state_t             state;
  logic [RESP_W-1:0]  sr;       // working shift register
  logic [CNT_W-1:0]   cnt;      // se_in-low cycles seen in this run
  logic [CNT_W-1:0]   cnt_inc;  // saturating increment of cnt
  logic               ovf;      // sticky: bits have fallen off the MSB

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_inc = cnt;
    if (cnt != '1) begin
      cnt_inc = cnt + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register is reset along with everything else; it is a
      // plain register (not a RAM) and the outputs must read 0 after reset.
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      resp_data  <= '0;
      resp_len   <= '0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      err_len    <= 1'b0;
      err_ovf    <= 1'b0;
    end else if (state != IDLE && !capture_start) begin
      // Abort: back to IDLE without loading partial data; the last published
      // resp_data/resp_len stay visible.
      state      <= IDLE;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      err_len    <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (capture_start) begin
            state   <= ARMED;
            sr      <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            err_len <= 1'b0;
            err_ovf <= 1'b0;
            busy    <= 1'b1;
          end
        end

        ARMED: begin
          // No timeout: wait indefinitely for the window to open. The edge
          // that sees se_in low already captures the first bit.
          if (!se_in) begin
            state <= SHIFT;
            sr    <= {sr[RESP_W-2:0], scan_in};
            cnt   <= CNT_W'(1);
          end
        end

        SHIFT: begin
          if (!se_in) begin
            sr  <= {sr[RESP_W-2:0], scan_in};
            cnt <= cnt_inc;
            // The bit entering now is number cnt+1; past RESP_W bits the
            // oldest one drops off the MSB.
            if (32'(cnt) >= RESP_W) begin
              ovf <= 1'b1;
            end
          end else begin
            state      <= DONE;
            resp_data  <= sr;
            resp_len   <= cnt;
            err_len    <= (cnt != l_scan);
            err_ovf    <= ovf;
            resp_valid <= 1'b1;
            busy       <= 1'b0;
          end
        end

        DONE: begin
          // Frozen until capture_start drops; later windows are ignored.
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef PUF_MISR_EN
  logic        misr_seed_load;
  logic        misr_shift_en;
  logic        misr_done_load;
  logic [15:0] misr_live;

  // Strobes mirror the FSM transitions above; an abort (capture_start low)
  // never shifts or publishes.
  assign misr_seed_load = (state == IDLE) && capture_start;
  assign misr_shift_en  = capture_start && !se_in &&
                          ((state == ARMED) || (state == SHIFT));
  assign misr_done_load = capture_start && se_in && (state == SHIFT);

  puf_misr16 u_misr (
    .clk       (clk),
    .rst       (rst),
    .seed_load (misr_seed_load),
    .shift_en  (misr_shift_en),
    .din       (scan_in),
    .sig       (misr_live)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      misr_sig <= '0;
    end else if (misr_done_load) begin
      misr_sig <= misr_live;
    end
  end
`endif

endmodule : puf_scan_response_capture
